// File: rtl/fetch_unit_if.sv
// Fetch unit bus: imem request/response, redirect and decode handshake.
// master = fetch unit side, slave = memory/pipeline side.
interface fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [DATA_WIDTH-1:0] imem_rsp_data;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        output instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, 2-entry buffer
// toward decode; a redirect flushes the buffer and restarts fetch.
module fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dat_q [2];
    logic [DATA_WIDTH-1:0] dat_d [2];
    logic [ADDR_WIDTH-1:0] bpc_q [2];
    logic [ADDR_WIDTH-1:0] bpc_d [2];
    logic                  req_fire;
    logic                  push;
    logic                  pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_REQ;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ:  if (req_fire) state_d = S_WAIT;
            // a response always ends the transaction, killed or not
            S_WAIT: begin
                if (bus.imem_rsp_valid) state_d = S_REQ;
                else if (bus.redirect)  state_d = S_KILL;
            end
            S_KILL: if (bus.imem_rsp_valid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        bus.imem_req_valid = 1'b0;
        bus.imem_req_addr  = pc_q;
        bus.instr_valid    = (cnt_q != 2'd0) && !bus.redirect;
        bus.instr          = '0;
        bus.instr_pc       = '0;
        push               = 1'b0;
        if (cnt_q != 2'd0) begin
            bus.instr    = dat_q[0];
            bus.instr_pc = bpc_q[0];
        end
        unique case (state_q)
            S_REQ:  bus.imem_req_valid = !rst && !bus.redirect
                                      && (cnt_q != 2'd2);
            S_WAIT: push = bus.imem_rsp_valid && !bus.redirect;
            default: ;
        endcase
    end

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign pop      = bus.instr_valid && bus.instr_ready;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        cnt_d    = cnt_q;
        dat_d    = dat_q;
        bpc_d    = bpc_q;
        if (bus.redirect) begin
            pc_d  = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            cnt_d = '0;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + ADDR_WIDTH'(4);
                req_pc_d = pc_q;
            end
            // entry 0 is always the head; pops shift entry 1 down
            unique case ({push, pop})
                2'b10: begin
                    dat_d[cnt_q[0]] = bus.imem_rsp_data;
                    bpc_d[cnt_q[0]] = req_pc_q;
                    cnt_d           = cnt_q + 2'd1;
                end
                2'b01: begin
                    dat_d[0] = dat_q[1];
                    bpc_d[0] = bpc_q[1];
                    cnt_d    = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        dat_d[0] = bus.imem_rsp_data;
                        bpc_d[0] = req_pc_q;
                    end else begin
                        dat_d[0] = dat_q[1];
                        bpc_d[0] = bpc_q[1];
                        dat_d[1] = bus.imem_rsp_data;
                        bpc_d[1] = req_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                dat_q[i] <= '0;
                bpc_q[i] <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
            bpc_q    <= bpc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: directed phases plus random traffic, all checked
// against a queue-based model of fetch order, flushes and buffering.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (RST_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_live;
    int          dly;
    int          total = 0;
    int          bad = 0;
    int          p_ready, p_iready, p_redir, lat_max;
    bit          xfer_seen;
    logic [31:0] xfer_addr;
    logic        last_iv, last_rv;
    logic [31:0] last_ipc;
    bit          got;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc   = RST_PC;
        m_out  = 1'b0;
        m_live = 1'b0;
        dly    = 0;
    endtask

    task automatic drive();
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.instr_ready    = ($urandom_range(99) < p_iready);
        bus.redirect       = ($urandom_range(99) < p_redir);
        bus.redirect_pc    = $urandom;
        bus.imem_rsp_valid = m_out && (dly == 0);
        bus.imem_rsp_data  = bus.imem_rsp_valid ? mem_word(m_addr)
                                                : $urandom;
    endtask

    // called at posedge+1; checks at negedge, model steps at posedge
    task automatic tick();
        bit          er, ev, xf, pp, rv, red;
        logic [31:0] rpc, rdat;
        ent_t        h;
        if (rst) model_reset();
        #4;
        red = bus.redirect;
        rpc = bus.redirect_pc;
        rv  = bus.imem_rsp_valid;
        rdat = bus.imem_rsp_data;
        er = !rst && !m_out && (q.size() < 2) && !red;
        ev = (q.size() > 0) && !red;
        h  = (q.size() > 0) ? q[0] : '0;
        chk("req_valid", bus.imem_req_valid, er);
        if (er) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("instr_valid", bus.instr_valid, ev);
        chk("instr", bus.instr, h.data);
        chk("instr_pc", bus.instr_pc, h.pc);
        last_iv  = bus.instr_valid;
        last_rv  = bus.imem_req_valid;
        last_ipc = bus.instr_pc;
        xf = er && bus.imem_req_ready;
        pp = ev && bus.instr_ready;
        xfer_seen = xf;
        xfer_addr = m_pc;
        @(posedge clk);
        if (!rst) begin
            if (pp) void'(q.pop_front());
            if (red) begin
                q.delete();
                m_pc = {rpc[31:2], 2'b00};
                if (m_out) begin
                    if (rv) m_out = 1'b0;
                    else begin
                        m_live = 1'b0;
                        if (dly > 0) dly--;
                    end
                end
            end else begin
                if (m_out) begin
                    if (rv) begin
                        if (m_live) q.push_back({m_addr, rdat});
                        m_out = 1'b0;
                    end else if (dly > 0) dly--;
                end
                if (xf) begin
                    m_addr = m_pc;
                    m_pc   = m_pc + 32'd4;
                    m_out  = 1'b1;
                    m_live = 1'b1;
                    dly    = $urandom_range(lat_max);
                end
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive();
            tick();
        end
    endtask

    task automatic wait_out();
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (m_out) got = 1'b1;
            else begin
                drive();
                tick();
            end
        end
        chk("outstanding_seen", got, 1);
    endtask

    task automatic wait_xfer(input string tag, input logic [31:0] want);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            drive();
            tick();
            got = xfer_seen;
        end
        chk({tag, "_seen"}, got, 1);
        if (got) chk(tag, xfer_addr, want);
    endtask

    initial begin
        rst = 1'b1;
        p_ready = 100; p_iready = 100; p_redir = 0; lat_max = 0;
        model_reset();
        drive();
        @(posedge clk);
        #1;
        drive(); tick();
        drive(); tick();
        chk("rst_iv", last_iv, 0);
        chk("rst_rv", last_rv, 0);

        // release: first request at RESET_PC, data two cycles later
        rst = 1'b0;
        drive(); tick();
        chk("first_xfer", xfer_seen, 1);
        chk("first_addr", xfer_addr, RST_PC);
        drive(); tick();
        chk("lat_n1_iv", last_iv, 0);
        drive(); tick();
        chk("lat_n2_iv", last_iv, 1);
        chk("lat_n2_pc", last_ipc, RST_PC);
        run(20);

        // decode stall: buffer fills, fetch stops
        p_iready = 0;
        run(10);
        chk("stall_iv", last_iv, 1);
        chk("stall_rv", last_rv, 0);
        p_iready = 100;
        run(10);

        // redirect while waiting: response dropped, aligned target
        wait_out();
        dly = 2;
        drive();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        tick();
        chk("c_red_iv", last_iv, 0);
        chk("c_red_rv", last_rv, 0);
        wait_xfer("c_addr", 32'h0000_0100);
        run(6);

        // redirect together with the response
        wait_out();
        dly = 0;
        drive();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        tick();
        chk("d_red_iv", last_iv, 0);
        wait_xfer("d_addr", 32'h0000_0200);
        run(6);

        // pc wraps at the top of the address space
        drive();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        tick();
        wait_xfer("e_top", 32'hFFFF_FFFC);
        wait_xfer("e_wrap", 32'h0000_0000);
        run(6);

        // reset during WAIT, stray responses ignored
        lat_max = 3;
        wait_out();
        dly = 3;
        drive(); tick();
        rst = 1'b1;
        drive();
        bus.imem_rsp_valid = 1'b1;
        tick();
        drive();
        bus.imem_rsp_valid = 1'b1;
        tick();
        chk("f_rst_iv", last_iv, 0);
        rst = 1'b0;
        drive();
        bus.imem_rsp_valid = 1'b1;
        tick();
        chk("f_xfer", xfer_seen, 1);
        chk("f_addr", xfer_addr, RST_PC);
        run(10);

        // random traffic
        p_ready = 70; p_iready = 60; p_redir = 5; lat_max = 3;
        run(3000);
        p_redir = 0;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
